spi_master_ctrl: RTL



---
 rtl/spi_master_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
`timescale 1ns/1ps
// Single-lane SPI master: sends 10-bit {opcode, payload} words MSB-first and, for
// read-data frames, waits RD_LATENCY cycles then shifts an 8-bit reply in from miso.
module spi_master_ctrl #(
   parameter int RD_LATENCY = 2,
   parameter int IDLE_GAP   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [9:0] tx_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       mosi,
   input  logic       miso,
   output logic       ss_n
);

   typedef enum logic [2:0] {IDLE, SEL, CMD, SHIFT, WAIT, CAPTURE, GAP} state_t;

   localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 1);
   localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

   state_t     state;
   logic [9:0] shreg;
   logic [6:0] rx_shreg;
   logic [3:0] cnt;
   logic       is_read;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         rx_shreg <= '0;
         cnt      <= '0;
         is_read  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         mosi     <= 1'b1;
         ss_n     <= 1'b1;
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_start) begin
                  shreg   <= tx_data;
                  is_read <= (tx_data[9:8] == 2'b11);
                  mosi    <= tx_data[9];
                  ss_n    <= 1'b0;
                  busy    <= 1'b1;
                  state   <= SEL;
               end
            end
            SEL: begin
               state <= CMD;
            end
            CMD: begin
               // mosi already shows bit 9; the shift register runs one bit ahead of mosi
               mosi  <= shreg[9];
               shreg <= {shreg[8:0], 1'b0};
               cnt   <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               if (cnt == 4'd9) begin
                  cnt  <= '0;
                  mosi <= 1'b1;
                  if (is_read) begin
                     state <= WAIT;
                  end else begin
                     ss_n  <= 1'b1;
                     done  <= (GAP_LAST == 4'd0);
                     state <= GAP;
                  end
               end else begin
                  mosi  <= shreg[9];
                  shreg <= {shreg[8:0], 1'b0};
                  cnt   <= cnt + 4'd1;
               end
            end
            WAIT: begin
               if (cnt == WAIT_LAST) begin
                  cnt   <= '0;
                  state <= CAPTURE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            CAPTURE: begin
               rx_shreg <= {rx_shreg[5:0], miso};
               if (cnt == 4'd7) begin
                  rd_data  <= {rx_shreg, miso};
                  cnt      <= '0;
                  ss_n     <= 1'b1;
                  done     <= (GAP_LAST == 4'd0);
                  rd_valid <= (GAP_LAST == 4'd0);
                  state    <= GAP;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt      <= cnt + 4'd1;
                  done     <= (cnt + 4'd1 == GAP_LAST);
                  rd_valid <= (cnt + 4'd1 == GAP_LAST) && is_read;
               end
            end
            default: begin
               ss_n  <= 1'b1;
               mosi  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
